// File: rtl/ysyx_201979054_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_201979054_axi_pkg
// Shared types for the AXI burst responder: response codes and the burst
// FSM state encoding.
// ---------------------------------------------------------------------------
package ysyx_201979054_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        OKAY   = RESP_OKAY,
        SLVERR = RESP_SLVERR
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        WRESP
    } burst_state_t;

endpackage

// File: rtl/ysyx_201979054_beat_counter.sv
// ---------------------------------------------------------------------------
// ysyx_201979054_beat_counter
// Counts beats within a fixed-length burst and flags the final beat.
// Ports:
//   clk, arst  clock and asynchronous active-high reset
//   clear      restart the count at beat 0 (burst start)
//   inc        one beat completed
//   last       current beat is beat BURST_LEN-1
// ---------------------------------------------------------------------------
module ysyx_201979054_beat_counter #(
    parameter int BURST_LEN = 16
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(BURST_LEN - 1);

    logic [CW-1:0] count;

    // Wraps back to 0 when the final beat completes, so the next burst
    // starts clean even without an explicit clear.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == LAST_VAL) ? '0 : count + 1'b1;
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/ysyx_201979054_axi_burst_responder.sv
// ---------------------------------------------------------------------------
// ysyx_201979054_axi_burst_responder
// Subordinate memory endpoint serving fixed-length read and write bursts
// from a word-addressed RAM (no len field; every burst is BURST_LEN beats).
// Ports:
//   clk, arst                      clock, asynchronous active-high reset
//   arvalid/arready/araddr         read address channel
//   rvalid/rready/rdata/rresp/rlast read data channel (rresp always OKAY)
//   awvalid/awready/awaddr         write address channel
//   wvalid/wready/wdata/wstrb/wlast write data channel
//   bvalid/bready/bresp            write response (SLVERR on wlast mismatch)
// ---------------------------------------------------------------------------
module ysyx_201979054_axi_burst_responder
    import ysyx_201979054_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    burst_state_t          state;
    logic [IDX_W-1:0]      index;
    logic [IDX_W-1:0]      next_index;
    logic [IDX_W-1:0]      ar_index;
    logic [IDX_W-1:0]      aw_index;
    logic                  err;
    resp_t                 bresp_q;
    logic                  beat_last;
    logic                  ar_hs;
    logic                  aw_hs;
    logic                  r_hs;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Byte-offset and high address bits do not select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr, awaddr};

    assign ar_index   = araddr[IDX_W+OFF_W-1:OFF_W];
    assign aw_index   = awaddr[IDX_W+OFF_W-1:OFF_W];
    assign next_index = index + 1'b1;

    // Read wins a same-cycle tie, so AW is held off while arvalid is up.
    assign arready = (state == IDLE);
    assign awready = (state == IDLE) & ~arvalid;
    assign wready  = (state == WR);

    assign ar_hs = arvalid & arready;
    assign aw_hs = awvalid & awready;
    assign r_hs  = (state == RD) & rvalid & rready;
    assign w_hs  = (state == WR) & wvalid;

    assign rlast = (state == RD) & beat_last;
    assign rresp = RESP_OKAY;
    assign bresp = bresp_q;

    ysyx_201979054_beat_counter #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_counter (
        .clk   (clk),
        .arst  (arst),
        .clear (ar_hs | aw_hs),
        .inc   (r_hs | w_hs),
        .last  (beat_last)
    );

    // Storage is deliberately unreset so contents survive an arst pulse.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // rdata is prefetched one beat ahead: the AR handshake loads beat 0 and
    // each accepted beat loads the following word, so rready held high gives
    // one beat per cycle. A wlast mismatch on an early beat is remembered in
    // err; the final beat folds in its own check when forming bresp.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            index   <= '0;
            err     <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            bvalid  <= 1'b0;
            bresp_q <= OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        index  <= ar_index;
                        rdata  <= mem[ar_index];
                        rvalid <= 1'b1;
                        state  <= RD;
                    end else if (aw_hs) begin
                        index <= aw_index;
                        err   <= 1'b0;
                        state <= WR;
                    end
                end
                RD: begin
                    if (r_hs) begin
                        index <= next_index;
                        if (beat_last) begin
                            rvalid <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            rdata <= mem[next_index];
                        end
                    end
                end
                WR: begin
                    if (w_hs) begin
                        index <= next_index;
                        if (beat_last) begin
                            bvalid  <= 1'b1;
                            bresp_q <= (err | ~wlast) ? SLVERR : OKAY;
                            err     <= 1'b0;
                            state   <= WRESP;
                        end else if (wlast) begin
                            err <= 1'b1;
                        end
                    end
                end
                WRESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
